univ_shift_reg_cmd: RTL and testbench

Parametrised, command-driven successor to the 8-bit universal shift register. It accepts one command at a time over a valid/ready handshake and executes multi-step shifts autonomously at one bit per clock, signalling completion with a one-cycle `done` pulse. Supported operations are load, logical shift, rotate and arithmetic shift, with independent serial inputs for each direction. It sits between a control sequencer and serial/parallel datapaths such as SPI-style serialisers and bit-field extractors.

---
 rtl/usr_pkg.sv | 32 +++
 rtl/usr_shift_step.sv | 27 ++
 rtl/univ_shift_reg_cmd.sv | 126 ++++++++++++
 tb/tb_univ_shift_reg_cmd.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the command-driven universal shift register.
package usr_pkg;

    // Operation codes carried on cmd_op.
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_LOAD = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSVD = 3'b111
    } usr_op_e;

    // Control states: waiting for a command, or stepping through a shift.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

    // True for the ops that move bits one position per step.
    function automatic logic is_shift_op(input usr_op_e op);
        logic res;
        case (op)
            OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Single-step next-value generator for every shift/rotate mode.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  usr_op_e          op,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next
);

    // Select the one-bit move for the requested mode; anything else holds.
    always_comb begin
        q_next = q;
        case (op)
            OP_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            OP_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_cmd.sv
// Command-driven universal shift register: accepts one command over
// valid/ready and executes multi-step shifts at one bit per clock.
module univ_shift_reg_cmd
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};

    usr_state_e       state_r, state_s;
    usr_op_e          op_r, op_s;
    logic [CNT_W-1:0] remaining_r, remaining_s;
    logic [WIDTH-1:0] q_r, q_s;
    logic [WIDTH-1:0] step_q_s;
    logic             done_r, done_s;
    usr_op_e          cmd_op_s;

    assign cmd_op_s = usr_op_e'(cmd_op);

    // The latched op drives the stepper; it only matters while running.
    usr_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_r),
        .op     (op_r),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (step_q_s)
    );

    // Next-state logic: clear beats everything, then accept in IDLE or step in RUN.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        remaining_s = remaining_r;
        q_s         = q_r;
        done_s      = 1'b0;
        if (clr) begin
            // Aborts any operation silently; a same-edge command is consumed and dropped.
            state_s     = ST_IDLE;
            op_s        = OP_NOP;
            remaining_s = CNT_ZERO;
            q_s         = Q_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op_s == OP_LOAD) begin
                            q_s    = d;
                            done_s = 1'b1;
                        end else if (is_shift_op(cmd_op_s) && (cmd_cnt != CNT_ZERO)) begin
                            // First step happens on the following edge.
                            state_s     = ST_RUN;
                            op_s        = cmd_op_s;
                            remaining_s = cmd_cnt;
                        end else begin
                            // NOP, reserved, or zero-length shift: completes immediately.
                            done_s = 1'b1;
                        end
                    end else begin
                        done_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    q_s         = step_q_s;
                    remaining_s = remaining_r - CNT_ONE;
                    if (remaining_r == CNT_ONE) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        done_s  = 1'b0;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    remaining_s = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter, data and completion registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NOP;
            remaining_r <= CNT_ZERO;
            q_r         <= Q_ZERO;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            remaining_r <= remaining_s;
            q_r         <= q_s;
            done_r      <= done_s;
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_RUN);
    assign done      = done_r;
    assign q         = q_r;
    assign sout_l    = q_r[WIDTH-1];
    assign sout_r    = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg_cmd.sv
// Self-checking bench: directed scenarios plus randomized traffic against
// a cycle-level arithmetic model of the command/shift behaviour.
module tb_univ_shift_reg_cmd;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int MOD   = 1 << W;
    localparam int HALF  = 1 << (W - 1);

    logic          clk;
    logic          reset_n;
    logic          clr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_cnt;
    logic [W-1:0]  d;
    logic          sin_l;
    logic          sin_r;
    logic [W-1:0]  q;
    logic          sout_l;
    logic          sout_r;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_q     = 0;
    int m_left  = 0;
    int m_op    = 0;
    bit m_done  = 1'b0;
    bit m_acc   = 1'b0;

    univ_shift_reg_cmd #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .d         (d),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .busy      (busy),
        .done      (done)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One step of an op, written as integer arithmetic on the register value.
    function automatic int model_step(input int v, input int op, input bit sl, input bit sr);
        case (op)
            1:       return ((v * 2) % MOD) + int'(sl);
            2:       return (v / 2) + int'(sr) * HALF;
            4:       return ((v * 2) % MOD) + (v / HALF);
            5:       return (v / 2) + (v % 2) * HALF;
            6:       return (v / 2) + ((v >= HALF) ? HALF : 0);
            default: return v;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs applied before it.
    task automatic model_edge();
        m_acc = cmd_valid && (m_left == 0);
        if (clr) begin
            m_q = 0; m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_q    = model_step(m_q, m_op, sin_l, sin_r);
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else begin
            m_done = 1'b0;
            if (cmd_valid) begin
                if (cmd_op == 3'd3) begin
                    m_q = int'(d); m_done = 1'b1;
                end else if ((cmd_op inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) && (cmd_cnt != 4'd0)) begin
                    m_left = int'(cmd_cnt); m_op = int'(cmd_op);
                end else begin
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("q",      32'(q),         32'(m_q));
        check("busy",   32'(busy),      32'(m_left > 0));
        check("done",   32'(done),      32'(m_done));
        check("ready",  32'(cmd_ready), 32'(m_left == 0));
        check("sout_l", 32'(sout_l),    32'((m_q / HALF) % 2));
        check("sout_r", 32'(sout_r),    32'(m_q % 2));
    endtask

    // Advance one clock; compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] data);
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; d = data;
    endtask

    task automatic issue(input logic [2:0] op, input logic [CW-1:0] cnt, input logic [W-1:0] data);
        drive_cmd(op, cnt, data);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset_n = 1'b0; clr = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0;
        cmd_cnt = 4'd0; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;

        // Reset state
        #12;
        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        reset_n = 1'b1;
        run_n(2);

        // LOAD 0xD3
        issue(3'd3, 4'd5, 8'hD3);
        check("load_q", 32'(q), 32'hD3);
        check("load_done", 32'(done), 32'h1);
        check("load_busy", 32'(busy), 32'h0);
        check("sout_l_pre1", 32'(sout_l), 32'h1);
        cycle();
        check("load_done_once", 32'(done), 32'h0);

        // SHL x3 with sin_l=1
        sin_l = 1'b1;
        issue(3'd1, 4'd3, 8'h00);
        check("shl_busy", 32'(busy), 32'h1);
        cycle();
        check("shl_q1", 32'(q), 32'hA7);
        check("sout_l_pre2", 32'(sout_l), 32'h1);
        cycle();
        check("shl_q2", 32'(q), 32'h4F);
        check("sout_l_pre3", 32'(sout_l), 32'h0);
        cycle();
        check("shl_q3", 32'(q), 32'h9F);
        check("shl_done", 32'(done), 32'h1);
        sin_l = 1'b0;

        // ROR by WIDTH and WIDTH+1
        issue(3'd5, 4'd8, 8'h00);
        run_n(8);
        check("ror8", 32'(q), 32'h9F);
        issue(3'd5, 4'd9, 8'h00);
        run_n(9);
        check("ror9", 32'(q), 32'hCF);

        // ASR x2 from 0x90
        issue(3'd3, 4'd0, 8'h90);
        issue(3'd6, 4'd2, 8'h00);
        run_n(2);
        check("asr2", 32'(q), 32'hE4);

        // Zero-count shift
        issue(3'd1, 4'd0, 8'h00);
        check("shl0_q", 32'(q), 32'hE4);
        check("shl0_done", 32'(done), 32'h1);

        // clr during 3rd busy cycle of SHR x5
        issue(3'd3, 4'd0, 8'hFF);
        issue(3'd2, 4'd5, 8'h00);
        run_n(2);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_q", 32'(q), 32'h00);
        check("clr_done", 32'(done), 32'h0);
        check("clr_ready", 32'(cmd_ready), 32'h1);
        cycle();

        // Asynchronous reset mid-run
        issue(3'd3, 4'd0, 8'hFF);
        issue(3'd2, 4'd5, 8'h00);
        run_n(2);
        #3 reset_n = 1'b0;
        #1;
        m_q = 0; m_left = 0; m_done = 1'b0;
        check("arst_q", 32'(q), 32'h00);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ready", 32'(cmd_ready), 32'h1);
        #1 reset_n = 1'b1;
        cycle();
        check("arst_done", 32'(done), 32'h0);

        // Back-to-back with cmd_valid held high
        drive_cmd(3'd1, 4'd2, 8'h00);
        cycle();
        drive_cmd(3'd3, 4'd0, 8'h5A);
        cycle();
        check("b2b_not_taken", 32'(q), 32'h00);
        cycle();
        check("b2b_done", 32'(done), 32'h1);
        check("b2b_ready", 32'(cmd_ready), 32'h1);
        cycle();
        check("b2b_q", 32'(q), 32'h5A);
        check("b2b_done2", 32'(done), 32'h1);
        cmd_valid = 1'b0;
        cycle();

        // Randomized traffic; the source holds its command until consumed.
        for (int i = 0; i < 1500; i++) begin
            if (!cmd_valid || m_acc) begin
                cmd_valid = ($urandom_range(0, 9) < 7);
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_cnt   = 4'($urandom_range(0, 11));
                d         = 8'($urandom_range(0, 255));
            end
            sin_l = 1'($urandom_range(0, 1));
            sin_r = 1'($urandom_range(0, 1));
            clr   = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clr = 1'b0; cmd_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
